mdu_seq: RTL and testbench

Iterative, parametrised multiply/divide unit for the PPC execute stage, succeeding the combinational MDU. It runs one radix-2 iteration per cycle (shift-add multiply, restoring divide) behind a start/busy/done handshake, so the pipeline stalls on `busy` instead of closing timing through an array multiplier. It returns the same result word and {OV, LT, GT, EQ} flag nibble for the CR0/XER update path. It adds three things the combinational MDU lacks: divide-by-zero and signed-overflow detection, a kill input, and correct signed CR0 compare.

---
 rtl/mdu_seq_if.sv | 26 ++
 rtl/mdu_seq.sv | 166 ++++++++++++++++
 tb/tb_mdu_seq.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_if.sv
// Handshake and operand bundle between the execute stage and the iterative MDU.
// Operand and result words use big-endian bit numbering, with bit 0 as the MSB.
interface mdu_seq_if #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 3
);
    logic                start;
    logic                kill;
    logic [OP_WIDTH-1:0] op;
    logic [0:WIDTH-1]    A;
    logic [0:WIDTH-1]    B;
    logic                busy;
    logic                done;
    logic [0:WIDTH-1]    C;
    logic [3:0]          D;

    modport master (
        output start, kill, op, A, B,
        input  busy, done, C, D
    );

    modport slave (
        input  start, kill, op, A, B,
        output busy, done, C, D
    );
endinterface

// File: rtl/mdu_seq.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide,
// with sign fix-up and {OV, LT, GT, EQ} flags computed in a final FIX cycle.
module mdu_seq #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    mdu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [OP_WIDTH-1:0] OP_MULH  = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_MULHU = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_MULW  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_DIVW  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_DIVWU = OP_WIDTH'(4);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t              state;
    logic [OP_WIDTH-1:0] op_q;
    logic                mul_q;
    logic                neg_q;
    logic                exc_q;
    logic                bad_q;
    logic [WIDTH-1:0]    opnd_q;
    logic [2*WIDTH-1:0]  acc;
    logic [CW-1:0]       cnt;
    logic                busy_q;
    logic                done_q;
    logic [WIDTH-1:0]    c_q;
    logic [3:0]          d_q;

    logic [WIDTH-1:0] a_in, b_in, a_mag, b_mag;
    logic             is_mul, is_div, sgn_op;
    logic             a_neg, b_neg, div_zero, div_ovf, early;

    assign a_in = bus.A;
    assign b_in = bus.B;

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        sgn_op = 1'b0;
        unique case (1'b1)
            bus.op == OP_MULH:  begin is_mul = 1'b1; sgn_op = 1'b1; end
            bus.op == OP_MULHU: is_mul = 1'b1;
            bus.op == OP_MULW:  begin is_mul = 1'b1; sgn_op = 1'b1; end
            bus.op == OP_DIVW:  begin is_div = 1'b1; sgn_op = 1'b1; end
            bus.op == OP_DIVWU: is_div = 1'b1;
            default: ;
        endcase
    end

    assign a_neg    = sgn_op & a_in[WIDTH-1];
    assign b_neg    = sgn_op & b_in[WIDTH-1];
    assign a_mag    = a_neg ? -a_in : a_in;
    assign b_mag    = b_neg ? -b_in : b_in;
    assign div_zero = is_div & (b_in == '0);
    assign div_ovf  = (bus.op == OP_DIVW)
                    & (a_in == {1'b1, {(WIDTH-1){1'b0}}})
                    & (b_in == '1);
    assign early    = div_zero | div_ovf | ~(is_mul | is_div);

    // Multiply: multiplier shifts out of the low half as the product shifts in.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + (acc[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: remainder in the high half, quotient bits enter at the bottom.
    logic [WIDTH:0]     div_t, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_r;
    logic [2*WIDTH-1:0] div_next;
    assign div_t    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff = div_t - {1'b0, opnd_q};
    assign div_ge   = ~div_diff[WIDTH];
    assign div_r    = div_ge ? div_diff[WIDTH-1:0] : div_t[WIDTH-1:0];
    assign div_next = {div_r, acc[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, res;
    logic               ov;
    logic [3:0]         flags;
    assign prod = neg_q ? -acc : acc;
    assign quot = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

    always_comb begin
        res = '0;
        ov  = 1'b0;
        unique case (1'b1)
            exc_q: ov = 1'b1;
            bad_q: ;
            (op_q == OP_MULH) || (op_q == OP_MULHU):
                res = prod[2*WIDTH-1:WIDTH];
            op_q == OP_MULW: begin
                res = prod[WIDTH-1:0];
                ov  = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
            end
            default: res = quot;
        endcase
    end

    assign flags = {ov, res[WIDTH-1], ~res[WIDTH-1] & (res != '0), res == '0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= '0;
            mul_q  <= 1'b0;
            neg_q  <= 1'b0;
            exc_q  <= 1'b0;
            bad_q  <= 1'b0;
            opnd_q <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            c_q    <= '0;
            d_q    <= 4'b0000;
        end else begin
            done_q <= 1'b0;
            if (bus.kill) begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: if (bus.start) begin
                        op_q   <= bus.op;
                        mul_q  <= is_mul;
                        neg_q  <= a_neg ^ b_neg;
                        exc_q  <= div_zero | div_ovf;
                        bad_q  <= ~(is_mul | is_div);
                        opnd_q <= is_mul ? a_mag : b_mag;
                        acc    <= {{WIDTH{1'b0}}, is_mul ? b_mag : a_mag};
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= early ? FIX : CALC;
                    end
                    CALC: begin
                        acc <= mul_q ? mul_next : div_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH-1))
                            state <= FIX;
                    end
                    FIX: begin
                        c_q    <= res;
                        d_q    <= flags;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.C    = c_q;
    assign bus.D    = d_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Testbench for mdu_seq: directed vector table, corner-case sequences and
// randomized operations against an arithmetic reference model.
module tb_mdu_seq;
    localparam int W = 32;
    localparam logic [2:0] MULH  = 3'd0;
    localparam logic [2:0] MULHU = 3'd1;
    localparam logic [2:0] MULW  = 3'd2;
    localparam logic [2:0] DIVW  = 3'd3;
    localparam logic [2:0] DIVWU = 3'd4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_seq_if #(.WIDTH(W), .OP_WIDTH(3)) bus();

    mdu_seq #(.WIDTH(W), .OP_WIDTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] last_c = '0;
    logic [3:0]  last_d = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [3:0]  d;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, sp;
        logic [63:0] up;
        logic [31:0] c;
        logic ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = sa * sb;
        up = {32'b0, a} * {32'b0, b};
        c = '0;
        ov = 1'b0;
        case (op)
            MULH:  c = sp[63:32];
            MULHU: c = up[63:32];
            MULW: begin
                c = sp[31:0];
                ov = sp[63:32] != {32{c[31]}};
            end
            DIVW:
                if (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ov = 1'b1;
                else c = 32'(sa / sb);
            DIVWU:
                if (b == 0) ov = 1'b1;
                else c = a / b;
            default: c = '0;
        endcase
        return {c, ov, $signed(c) < 0, $signed(c) > 0, c == 0};
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op > DIVWU) return 2;
        if ((op == DIVW || op == DIVWU) && b == 0) return 2;
        if (op == DIVW && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return W + 2;
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] ec, input logic [3:0] ed,
                          input string name);
        int n;
        bus.start = 1'b1;
        bus.op = op;
        bus.A = a;
        bus.B = b;
        @(negedge clk);
        bus.start = 1'b0;
        check({name, " busy"}, bus.busy, 1'b1);
        n = 1;
        while (!bus.done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, " done"}, bus.done, 1'b1);
        check({name, " lat"}, n, lat);
        check({name, " C"}, bus.C, ec);
        check({name, " D"}, bus.D, ed);
        check({name, " busy_at_done"}, bus.busy, 1'b0);
        last_c = ec;
        last_d = ed;
    endtask

    vec_t tbl[12];

    initial begin
        logic [35:0] exp;
        logic [2:0] rop;
        logic [31:0] ra, rb;
        int n;

        tbl[0]  = '{MULW,  32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b1001, 34};
        tbl[1]  = '{MULH,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 4'b0010, 34};
        tbl[2]  = '{MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0100, 34};
        tbl[3]  = '{MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0001, 34};
        tbl[4]  = '{DIVW,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 4'b0100, 34};
        tbl[5]  = '{DIVWU, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 4'b0010, 34};
        tbl[6]  = '{DIVW,  32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 4'b1001, 2};
        tbl[7]  = '{DIVW,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1001, 2};
        tbl[8]  = '{DIVWU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 4'b1001, 2};
        tbl[9]  = '{3'd7,  32'h1234_5678, 32'h0000_0003, 32'h0000_0000, 4'b0001, 2};
        tbl[10] = '{MULW,  32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 4'b1100, 34};
        tbl[11] = '{MULHU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 4'b0010, 34};

        bus.start = 1'b0;
        bus.kill = 1'b0;
        bus.op = '0;
        bus.A = '0;
        bus.B = '0;

        #12;
        check("rst busy", bus.busy, 1'b0);
        check("rst done", bus.done, 1'b0);
        check("rst C", bus.C, 32'h0);
        check("rst D", bus.D, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Consecutive entries start in the done cycle of the previous one.
        for (int i = 0; i < 12; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lat,
                   tbl[i].c, tbl[i].d, $sformatf("vec%0d", i));

        @(negedge clk);
        check("done width", bus.done, 1'b0);

        // start while busy must not disturb the in-flight result
        bus.start = 1'b1;
        bus.op = MULW;
        bus.A = 32'd3;
        bus.B = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        repeat (4) begin @(negedge clk); n++; end
        bus.start = 1'b1;
        bus.op = DIVWU;
        bus.A = 32'd100;
        bus.B = 32'd7;
        @(negedge clk);
        n++;
        bus.start = 1'b0;
        while (!bus.done && n < 60) begin @(negedge clk); n++; end
        check("busy_start done", bus.done, 1'b1);
        check("busy_start lat", n, 34);
        check("busy_start C", bus.C, 32'd15);
        check("busy_start D", bus.D, 4'b0010);
        last_c = 32'd15;
        last_d = 4'b0010;
        @(negedge clk);
        check("busy_start no_rerun", bus.busy, 1'b0);

        // kill at cycle 10 of a DIVWU
        bus.start = 1'b1;
        bus.op = DIVWU;
        bus.A = 32'd1000;
        bus.B = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill busy", bus.busy, 1'b0);
        check("kill done", bus.done, 1'b0);
        check("kill C", bus.C, last_c);
        check("kill D", bus.D, last_d);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) n++;
        end
        check("kill no_done", n, 0);

        // kill together with start in IDLE
        bus.kill = 1'b1;
        bus.start = 1'b1;
        bus.op = MULW;
        @(negedge clk);
        bus.kill = 1'b0;
        bus.start = 1'b0;
        check("kill_start busy", bus.busy, 1'b0);
        @(negedge clk);
        check("kill_start idle", bus.busy, 1'b0);

        run_op(DIVWU, 32'd1000, 32'd9, 34, 32'd111, 4'b0010, "after_kill");

        // asynchronous reset in the middle of CALC
        bus.start = 1'b1;
        bus.op = MULH;
        bus.A = 32'h7000_0000;
        bus.B = 32'h7000_0000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst busy", bus.busy, 1'b0);
        check("async_rst done", bus.done, 1'b0);
        check("async_rst C", bus.C, 32'h0);
        check("async_rst D", bus.D, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'($urandom_range(0, 255));
                default: ;
            endcase
            exp = model(rop, ra, rb);
            run_op(rop, ra, rb, latency(rop, ra, rb), exp[35:4], exp[3:0],
                   $sformatf("rnd%0d op%0d %h %h", i, rop, ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
